// File: rtl/serializer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serializer_pkg
// Shared state encoding and counter-width helper for the PISO serializer.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..value-1; at least one bit so a WIDTH=2 counter exists.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_shift_reg
// WIDTH-bit load/shift register with bit counter; fills with IDLE_BIT.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module piso_shift_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout_bit,
  output logic             last
);

  localparam int              c_CW   = clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_data;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_data[WIDTH-2:0], IDLE_BIT};
      assign sout_bit  = r_data[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {IDLE_BIT, r_data[WIDTH-1:1]};
      assign sout_bit  = r_data[0];
    end
  endgenerate

  assign last = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (load) begin
      r_data <= load_data;
      r_cnt  <= '0;
    end else if (shift_en) begin
      r_data <= w_shifted;
      // Reload to zero after the last bit so the count never passes WIDTH-1.
      r_cnt  <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule : piso_shift_reg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// piso_serializer
// Valid/ready word intake with one-entry hold buffer, gapless serial output.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_data;
  logic             w_shift_en;
  logic             w_hold_we;
  logic             w_hold_clr;
  logic             w_sr_bit;
  logic             w_last;

  assign din_ready = rst & ~r_hold_full;
  assign w_accept  = din_valid & din_ready;

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .IDLE_BIT  (IDLE_BIT)
  ) u_shift_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .load_data (w_load_data),
    .shift_en  (w_shift_en),
    .sout_bit  (w_sr_bit),
    .last      (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_we) begin
        r_hold      <= din;
        r_hold_full <= 1'b1;
      end else if (w_hold_clr) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = din;
    w_shift_en  = 1'b0;
    w_hold_we   = 1'b0;
    w_hold_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          // Held word wins; an accept cannot coincide since ready is low while full.
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_load_data = r_hold;
            w_hold_clr  = 1'b1;
          end else if (w_accept) begin
            w_load      = 1'b1;
          end else begin
            w_shift_en  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_shift_en = 1'b1;
          w_hold_we  = w_accept;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sout_valid = (r_state == ST_SHIFT);
  assign sout       = sout_valid ? w_sr_bit : IDLE_BIT;
  assign word_done  = sout_valid & w_last;
  assign busy       = sout_valid | r_hold_full;

endmodule : piso_serializer
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the 1011 overlapping sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on sout, which drives the detector's x input.
- A one-entry holding buffer lets consecutive words stream with no idle bit between them.
- Idle cycles emit IDLE_BIT so the detector sees a defined, non-matching level.

Parameters:
WIDTH, 8, word width in bits; legal values 2 and above.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
IDLE_BIT, 0, level driven on sout while no word is shifting.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din holds a word.
din_ready  output  1  block can take a word this cycle.
sout  output  1  serial bit; connects to the detector's x.
sout_valid  output  1  sout carries a data bit, not idle fill.
word_done  output  1  high during the cycle the last bit of a word is on sout.
busy  output  1  shifter active, or hold buffer full.

Behaviour:
- Reset (rst low, asynchronous):
  - Clears state to IDLE, bit counter to 0, hold_full to 0, shift register to 0.
  - Outputs while in reset: sout=IDLE_BIT, sout_valid=0, word_done=0, busy=0, din_ready=0.
  - Reset mid-word drops the partial word and any held word. Nothing resumes after release.
- Handshake:
  - din_ready = rst & ~hold_full.
  - A word is accepted on any posedge where din_valid & din_ready.
  - din_valid may be held across cycles. Each accepting edge takes exactly one word.
- Outputs:
  - sout and sout_valid are registered.
  - sout is the shift register's outgoing bit: MSB when MSB_FIRST=1, LSB otherwise.
- State IDLE:
  - sout=IDLE_BIT, sout_valid=0.
  - On acceptance, load the word straight into the shifter with cnt=0 and go to SHIFT.
  - The first bit is on sout in the cycle after the accepting edge (latency 1).
- State SHIFT:
  - Each edge shifts by one and increments cnt. The register is filled with IDLE_BIT as it shifts.
  - word_done=1 while cnt==WIDTH-1.
  - At the edge ending cnt==WIDTH-1, the next word comes from:
    - the hold buffer if hold_full, clearing hold_full, cnt=0, staying in SHIFT; else
    - the input if it is accepted on that same edge (bypass, no buffering), cnt=0, staying in SHIFT; else
    - nowhere: go to IDLE.
  - An acceptance on any other SHIFT edge writes the hold buffer and sets hold_full.
- Back-to-back words therefore give a gapless bit stream of exactly WIDTH bits per word.
- Simultaneous events:
  - Hold drained into the shifter on the same edge as a new word arrives: impossible, because din_ready=0 while hold_full.
  - Hold drained with din_valid high: din_ready rises the next cycle and the word is accepted then.
- busy = (state==SHIFT) | hold_full.
- Counter: width clog2(WIDTH). It wraps only via reload to 0 and never exceeds WIDTH-1.
- Hold-buffer content is irrelevant when hold_full=0.

Decomposition:
- Shared package serializer_pkg holds:
  - the state encoding (IDLE, SHIFT), as 1-bit constants;
  - the counter-width function clog2.
- One natural sub-module: piso_shift_reg.
  - Contents: WIDTH-bit load/shift register plus the bit counter.
  - Inputs: load, load_data, shift_en. Outputs: serial bit, last.
- The top level owns the FSM, hold buffer and handshake.

Test Plan:
- Reset, then din=8'hB0 with din_valid for one cycle -> sout 1,0,1,1,0,0,0,0 on the 8 cycles after acceptance; sout_valid=1 for those 8 cycles; word_done on the 8th; detector y=1 exactly once.
- Words 8'hB0 then 8'hDB presented back-to-back -> second word accepted into hold; 16 contiguous sout_valid cycles with no gap; din_ready=0 from hold fill until first word's last bit edge.
- din_valid held high with three words queued -> din_ready toggles so exactly one word is accepted per 8 cycles after the first two; order preserved; bits match MSB-first concatenation.
- rst pulled low at bit 4 of 8'hB0 with hold full -> outputs immediately sout=0, sout_valid=0, busy=0; after release no remnant bits and din_ready=1.
- MSB_FIRST=0, din=8'h0D -> sout 1,0,1,1,0,0,0,0; detector fires once.
- No input for 20 cycles after reset -> sout=IDLE_BIT constant, sout_valid=0, busy=0, word_done never asserted.
